// File: rtl/mult_pkg.sv
// ============================================================================
// Module      : mult_pkg
// Description : Shared state encoding and elaboration helpers for the
//               sequential shift-and-add multiplier.
// Revision    : 1.0 - initial release
// ============================================================================
`default_nettype none

package mult_pkg;

    typedef enum logic [1:0] {
        IDLE = 2'd0,
        CALC = 2'd1,
        DONE = 2'd2
    } state_t;

    // Ceiling log2, valid for value >= 1.
    function automatic int clog2(input int value);
        int r;
        r = 0;
        for (int v = value - 1; v > 0; v = v >> 1) begin
            r = r + 1;
        end
        return r;
    endfunction

endpackage

`default_nettype wire

// File: rtl/add_n.sv
// ============================================================================
// Module      : add_n
// Description : W-bit ripple-carry adder assembled from full_adder cells.
// Revision    : 1.0 - initial release
// ============================================================================
`default_nettype none

module add_n #(
    parameter int W = 16
) (
    input  logic [W-1:0] a,
    input  logic [W-1:0] b,
    input  logic         cin,
    output logic [W-1:0] sum,
    output logic         cout
);

    logic [W:0] w_carry;

    assign w_carry[0] = cin;
    assign cout       = w_carry[W];

    generate
        for (genvar i = 0; i < W; i++) begin : g_bit
            full_adder u_fa (
                .a    (a[i]),
                .b    (b[i]),
                .cin  (w_carry[i]),
                .sum  (sum[i]),
                .cout (w_carry[i+1])
            );
        end
    endgenerate

endmodule

`default_nettype wire

// File: rtl/full_adder.sv
// ============================================================================
// Module      : full_adder
// Description : Single-bit full adder cell.
// Revision    : 1.0 - initial release
// ============================================================================
`default_nettype none

module full_adder (
    input  logic a,
    input  logic b,
    input  logic cin,
    output logic sum,
    output logic cout
);

    assign sum  = a ^ b ^ cin;
    assign cout = (a & b) | (cin & (a ^ b));

endmodule

`default_nettype wire

// File: rtl/shift_add_multiplier.sv
// ============================================================================
// Module      : shift_add_multiplier
// Description : Sequential N x M multiplier, one partial product per cycle,
//               signed/unsigned operands, valid/ready handshakes on both sides.
// Revision    : 1.0 - initial release
// ============================================================================
`default_nettype none

module shift_add_multiplier
    import mult_pkg::*;
#(
    parameter int N = 8,
    parameter int M = 8
) (
    input  logic             clk,
    input  logic             rst_n,
    input  logic             in_valid,
    output logic             in_ready,
    input  logic [N-1:0]     a,
    input  logic [M-1:0]     b,
    input  logic             signed_mode,
    input  logic             flush,
    output logic             out_valid,
    input  logic             out_ready,
    output logic [N+M-1:0]   out
);

    localparam int P  = N + M;
    localparam int CW = clog2(M + 1);

    localparam logic [CW-1:0] c_last    = CW'(M - 1);
    localparam logic [CW-1:0] c_cnt_one = CW'(1);
    localparam logic [M-1:0]  c_b_one   = M'(1);

    state_t         r_state;
    state_t         w_next;
    logic [N-1:0]   r_mag_a;
    logic [M-1:0]   r_mag_b;
    logic           r_sign;
    logic [P-1:0]   r_acc;
    logic [CW-1:0]  r_cnt;
    logic [P-1:0]   r_out;

    logic [N-1:0]   w_mag_a;
    logic [M-1:0]   w_mag_b;
    logic           w_b_bit;
    logic [P-1:0]   w_addend;
    logic [P-1:0]   w_sum;
    logic           w_unused_cout;

    // Negating the most-negative value wraps back to itself, which read as
    // unsigned is exactly the required 2^(N-1) / 2^(M-1) magnitude.
    assign w_mag_a = (signed_mode && a[N-1]) ? -a : a;
    assign w_mag_b = (signed_mode && b[M-1]) ? -b : b;

    assign w_b_bit  = |(r_mag_b & (c_b_one << r_cnt));
    assign w_addend = w_b_bit ? ({{M{1'b0}}, r_mag_a} << r_cnt) : '0;

    add_n #(.W(P)) u_add (
        .a    (r_acc),
        .b    (w_addend),
        .cin  (1'b0),
        .sum  (w_sum),
        .cout (w_unused_cout)
    );

    always_ff @(posedge clk or negedge rst_n) begin
        if (!rst_n) begin
            r_state <= IDLE;
        end else begin
            r_state <= w_next;
        end
    end

    always_comb begin
        w_next = r_state;
        case (r_state)
            IDLE:    if (in_valid)         w_next = CALC;
            CALC:    if (r_cnt == c_last)  w_next = DONE;
            DONE:    if (out_ready)        w_next = IDLE;
            default:                       w_next = IDLE;
        endcase
        if (flush) begin
            w_next = IDLE;
        end
    end

    always_ff @(posedge clk or negedge rst_n) begin
        if (!rst_n) begin
            r_mag_a <= '0;
            r_mag_b <= '0;
            r_sign  <= 1'b0;
            r_acc   <= '0;
            r_cnt   <= '0;
            r_out   <= '0;
        end else if (!flush) begin
            case (r_state)
                IDLE: begin
                    if (in_valid) begin
                        r_mag_a <= w_mag_a;
                        r_mag_b <= w_mag_b;
                        r_sign  <= signed_mode & (a[N-1] ^ b[M-1]);
                        r_acc   <= '0;
                        r_cnt   <= '0;
                    end
                end
                CALC: begin
                    r_acc <= w_sum;
                    r_cnt <= r_cnt + c_cnt_one;
                    if (r_cnt == c_last) begin
                        r_out <= r_sign ? -w_sum : w_sum;
                    end
                end
                default: ;
            endcase
        end
    end

    assign in_ready  = (r_state == IDLE);
    assign out_valid = (r_state == DONE);
    assign out       = r_out;

endmodule

`default_nettype wire

// File: tb/tb_shift_add_multiplier.sv
// ============================================================================
// Module      : tb_shift_add_multiplier
// Description : Self-checking bench for shift_add_multiplier (8x8 and 3x8).
// Revision    : 1.0 - initial release
// ============================================================================
`default_nettype none

module tb_shift_add_multiplier;

    logic clk = 1'b0;
    logic rst_n;

    logic        iv8, rdy8, sm8, fl8, ov8, or8;
    logic [7:0]  a8, b8;
    logic [15:0] out8;

    logic        iv3, rdy3, sm3, fl3, ov3, or3;
    logic [2:0]  a3;
    logic [7:0]  b3;
    logic [10:0] out3;

    int cyc = 0;
    int n_cmp = 0;
    int n_bad = 0;

    always #5 clk = ~clk;
    always @(posedge clk) cyc <= cyc + 1;

    shift_add_multiplier #(.N(8), .M(8)) u_dut8 (
        .clk (clk), .rst_n (rst_n), .in_valid (iv8), .in_ready (rdy8),
        .a (a8), .b (b8), .signed_mode (sm8), .flush (fl8),
        .out_valid (ov8), .out_ready (or8), .out (out8)
    );

    shift_add_multiplier #(.N(3), .M(8)) u_dut3 (
        .clk (clk), .rst_n (rst_n), .in_valid (iv3), .in_ready (rdy3),
        .a (a3), .b (b3), .signed_mode (sm3), .flush (fl3),
        .out_valid (ov3), .out_ready (or3), .out (out3)
    );

    task automatic chk(input string name, input longint act, input longint exp);
        n_cmp++;
        if (act != exp) begin
            n_bad++;
            $display("FAIL %s: got 0x%0h, expected 0x%0h (t=%0t)", name, act, exp, $time);
        end
    endtask

    // Reference product: plain integer multiply, reduced modulo 2^(na+mb).
    function automatic longint model(input longint av, input longint bv, input bit sm,
                                     input int na, input int mb);
        longint sa, sb;
        sa = av;
        sb = bv;
        if (sm) begin
            if (av[na-1]) sa = av - (longint'(1) << na);
            if (bv[mb-1]) sb = bv - (longint'(1) << mb);
        end
        return (sa * sb) & ((longint'(1) << (na + mb)) - 1);
    endfunction

    // Transaction-level model per DUT: busy flag, cycle the product is due,
    // and the value out must show.
    bit     m_busy [2];
    int     m_due  [2];
    longint m_pend [2];
    longint m_last [2];

    always @(negedge clk) begin
        if (!rst_n) begin
            for (int k = 0; k < 2; k++) begin
                m_busy[k] = 1'b0;
                m_last[k] = 0;
            end
        end else begin
            for (int k = 0; k < 2; k++) begin
                bit     rdy, vld, iv, sm, fl, ordy, exp_vld;
                longint o, av, bv;
                int     na;
                if (k == 0) begin
                    rdy = rdy8; vld = ov8; iv = iv8; sm = sm8; fl = fl8; ordy = or8;
                    o = longint'(out8); av = longint'(a8); bv = longint'(b8); na = 8;
                end else begin
                    rdy = rdy3; vld = ov3; iv = iv3; sm = sm3; fl = fl3; ordy = or3;
                    o = longint'(out3); av = longint'(a3); bv = longint'(b3); na = 3;
                end
                if (m_busy[k] && cyc == m_due[k]) m_last[k] = m_pend[k];
                exp_vld = m_busy[k] && (cyc >= m_due[k]);
                chk(k == 0 ? "in_ready8"  : "in_ready3",  longint'(rdy), longint'(!m_busy[k]));
                chk(k == 0 ? "out_valid8" : "out_valid3", longint'(vld), longint'(exp_vld));
                chk(k == 0 ? "out8"       : "out3",       o, m_last[k]);
                if (fl) begin
                    m_busy[k] = 1'b0;
                end else if (!m_busy[k] && iv) begin
                    m_busy[k] = 1'b1;
                    m_due[k]  = cyc + 1 + 8;
                    m_pend[k] = model(av, bv, sm, na, 8);
                end else if (exp_vld && ordy) begin
                    m_busy[k] = 1'b0;
                end
            end
        end
    end

    task automatic op8(input logic [7:0] a, input logic [7:0] b, input bit sm,
                       input logic [15:0] exp, input string nm);
        int lat;
        a8 = a; b8 = b; sm8 = sm; iv8 = 1'b1;
        @(posedge clk); #1 iv8 = 1'b0;
        lat = 0;
        while (!ov8 && lat < 20) begin
            @(posedge clk); #1;
            lat++;
        end
        chk({nm, "_latency"}, lat, 8);
        chk({nm, "_out"}, longint'(out8), longint'(exp));
        if (or8) begin
            @(posedge clk); #1;
        end
    endtask

    task automatic op3(input logic [2:0] a, input logic [7:0] b, input bit sm);
        int lat;
        a3 = a; b3 = b; sm3 = sm; iv3 = 1'b1;
        @(posedge clk); #1 iv3 = 1'b0;
        lat = 0;
        while (!ov3 && lat < 20) begin
            @(posedge clk); #1;
            lat++;
        end
        chk("sweep_latency", lat, 8);
        @(posedge clk); #1;
    endtask

    initial begin
        #1_000_000;
        $display("FAIL watchdog: simulation time limit reached");
        $fatal(1, "watchdog");
    end

    initial begin
        rst_n = 1'b0;
        iv8 = 0; a8 = 0; b8 = 0; sm8 = 0; fl8 = 0; or8 = 1;
        iv3 = 0; a3 = 0; b3 = 0; sm3 = 0; fl3 = 0; or3 = 1;
        repeat (2) @(posedge clk);
        #1;
        chk("reset_in_ready", longint'(rdy8), 1);
        chk("reset_out_valid", longint'(ov8), 0);
        chk("reset_out", longint'(out8), 0);
        rst_n = 1'b1;
        @(posedge clk); #1;

        op8(8'd255, 8'd255, 1'b0, 16'hFE01, "u255x255");
        op8(8'h80,  8'h80,  1'b1, 16'h4000, "s_m128xm128");
        op8(8'hFF,  8'h01,  1'b1, 16'hFFFF, "s_m1x1");
        op8(8'h07,  8'hFD,  1'b1, 16'hFFEB, "s_7xm3");
        op8(8'h80,  8'h80,  1'b0, 16'h4000, "u128x128");
        op8(8'h00,  8'hAB,  1'b1, 16'h0000, "s_zero");

        // Back-pressure in DONE.
        or8 = 1'b0;
        op8(8'd3, 8'd5, 1'b0, 16'd15, "hold");
        for (int i = 0; i < 5; i++) begin
            @(posedge clk); #1;
            chk("hold_out", longint'(out8), 15);
            chk("hold_in_ready", longint'(rdy8), 0);
            chk("hold_out_valid", longint'(ov8), 1);
        end
        or8 = 1'b1;
        @(posedge clk); #1;
        chk("handshake_in_ready", longint'(rdy8), 1);
        chk("handshake_out_valid", longint'(ov8), 0);

        // Flush at CALC step 4, with operands held on the input meanwhile.
        a8 = 8'd9; b8 = 8'd9; sm8 = 1'b0; iv8 = 1'b1;
        @(posedge clk); #1 a8 = 8'd77;
        repeat (4) @(posedge clk);
        #1 fl8 = 1'b1; iv8 = 1'b0;
        @(posedge clk); #1 fl8 = 1'b0;
        chk("flush_out_valid", longint'(ov8), 0);
        chk("flush_in_ready", longint'(rdy8), 1);
        chk("flush_out_kept", longint'(out8), 15);

        // Flush beats a simultaneous accept in IDLE.
        a8 = 8'd5; b8 = 8'd5; iv8 = 1'b1; fl8 = 1'b1;
        @(posedge clk); #1 iv8 = 1'b0; fl8 = 1'b0;
        chk("flush_vs_accept", longint'(rdy8), 1);
        op8(8'd2, 8'd3, 1'b0, 16'd6, "after_flush");

        // Asynchronous reset in the middle of CALC.
        a8 = 8'd200; b8 = 8'd100; iv8 = 1'b1;
        @(posedge clk); #1 iv8 = 1'b0;
        repeat (3) @(posedge clk);
        #1 rst_n = 1'b0;
        #1;
        chk("midcalc_rst_out_valid", longint'(ov8), 0);
        chk("midcalc_rst_out", longint'(out8), 0);
        chk("midcalc_rst_in_ready", longint'(rdy8), 1);
        @(posedge clk); #1 rst_n = 1'b1;
        repeat (12) @(posedge clk);
        #1;
        op8(8'd12, 8'd12, 1'b0, 16'd144, "after_reset");

        // Exhaustive 3x8 sweep in both modes.
        for (int s = 0; s < 2; s++) begin
            for (int ai = 0; ai < 8; ai++) begin
                for (int bi = 0; bi < 256; bi++) begin
                    op3(3'(ai), 8'(bi), s[0]);
                end
            end
        end

        repeat (2) @(posedge clk);
        $display("*** SUMMARY: %0d compared / %0d mismatched ***", n_cmp, n_bad);
        $finish;
    end

endmodule

`default_nettype wire
